// File: rtl/nn_stimulus_driver.sv
// Host-loaded RNN job buffer: streams one job to the NN block over a 9-cycle
// in_valid burst, then collects and stores the 9-word out_valid response.
module nn_stimulus_driver #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 1000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [2:0]    wr_sel_i,
    input  logic [3:0]    wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_timeout_o,
    output logic          err_gap_o,
    output logic          err_spurious_o,
    input  logic [3:0]    rd_addr_i,
    output logic [DW-1:0] rd_data_o,
    output logic          in_valid_o,
    output logic [DW-1:0] data_x_o,
    output logic [DW-1:0] data_h_o,
    output logic [DW-1:0] weight_u_o,
    output logic [DW-1:0] weight_w_o,
    output logic [DW-1:0] weight_v_o,
    input  logic          out_valid_i,
    input  logic [DW-1:0] out_i
);
    localparam int             WCW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [3:0]     LAST_IDX  = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_COLLECT,
        S_FIN
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [WCW-1:0]  wait_q, wait_d;
    logic            err_timeout_q, err_timeout_d;
    logic            err_gap_q, err_gap_d;
    logic            err_spurious_q, err_spurious_d;
    logic            res_we;
    logic [3:0]      res_idx;
    logic            send_d;
    logic            wr_ok;

    // Arrays 0..4 hold weight_u, weight_w, weight_v, data_x, data_h.
    logic [DW-1:0]   in_mem_q  [5][9];
    logic [DW-1:0]   res_mem_q [9];

    logic            in_valid_q;
    logic [DW-1:0]   data_x_q, data_h_q, weight_u_q, weight_w_q, weight_v_q;
    logic [DW-1:0]   rd_data_q;

    assign busy_o = (state_q == S_SEND) || (state_q == S_WAIT) || (state_q == S_COLLECT);
    assign done_o = (state_q == S_FIN);

    assign wr_ok = wr_en_i && !busy_o && (wr_addr_i <= LAST_IDX) && (wr_sel_i <= 3'd4)
                   && !((wr_sel_i == 3'd4) && (wr_addr_i > 4'd2));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d        = state_q;
        idx_d          = idx_q;
        wait_d         = wait_q;
        err_timeout_d  = err_timeout_q;
        err_gap_d      = err_gap_q;
        err_spurious_d = err_spurious_q;
        res_we         = 1'b0;
        res_idx        = idx_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d        = S_SEND;
                    idx_d          = '0;
                    err_timeout_d  = 1'b0;
                    err_gap_d      = 1'b0;
                    err_spurious_d = 1'b0;
                end
            end
            S_SEND: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_WAIT;
                    wait_d  = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (out_valid_i) begin
                    res_we  = 1'b1;
                    res_idx = '0;
                    idx_d   = 4'd1;
                    state_d = S_COLLECT;
                end else if (wait_q == WAIT_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_FIN;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            S_COLLECT: begin
                if (out_valid_i) begin
                    res_we = 1'b1;
                    idx_d  = idx_q + 4'd1;
                    if (idx_q == LAST_IDX) state_d = S_FIN;
                end else begin
                    err_gap_d = 1'b1;
                    state_d   = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A response outside the window is flagged; seeing it alongside start still sets it.
        if (out_valid_i && ((state_q == S_IDLE) || (state_q == S_SEND) || (state_q == S_FIN)))
            err_spurious_d = 1'b1;
    end

    assign send_d = (state_d == S_SEND);

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            wait_q         <= '0;
            err_timeout_q  <= 1'b0;
            err_gap_q      <= 1'b0;
            err_spurious_q <= 1'b0;
            in_valid_q     <= 1'b0;
            data_x_q       <= '0;
            data_h_q       <= '0;
            weight_u_q     <= '0;
            weight_w_q     <= '0;
            weight_v_q     <= '0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            wait_q         <= wait_d;
            err_timeout_q  <= err_timeout_d;
            err_gap_q      <= err_gap_d;
            err_spurious_q <= err_spurious_d;
            in_valid_q     <= send_d;
            weight_u_q     <= send_d ? in_mem_q[0][idx_d] : '0;
            weight_w_q     <= send_d ? in_mem_q[1][idx_d] : '0;
            weight_v_q     <= send_d ? in_mem_q[2][idx_d] : '0;
            data_x_q       <= send_d ? in_mem_q[3][idx_d] : '0;
            data_h_q       <= (send_d && (idx_d < 4'd3)) ? in_mem_q[4][idx_d] : '0;
            rd_data_q      <= (rd_addr_i <= LAST_IDX) ? res_mem_q[rd_addr_i] : '0;
        end
    end

    // NOTE: storage arrays carry no reset; their contents are defined only by host writes and captures.
    always_ff @(posedge clk_i) begin
        if (wr_ok) in_mem_q[wr_sel_i][wr_addr_i] <= wr_data_i;
        if (res_we && !rst_i) res_mem_q[res_idx] <= out_i;
    end

    assign err_timeout_o  = err_timeout_q;
    assign err_gap_o      = err_gap_q;
    assign err_spurious_o = err_spurious_q;
    assign rd_data_o      = rd_data_q;
    assign in_valid_o     = in_valid_q;
    assign data_x_o       = data_x_q;
    assign data_h_o       = data_h_q;
    assign weight_u_o     = weight_u_q;
    assign weight_w_o     = weight_w_q;
    assign weight_v_o     = weight_v_q;

endmodule
